vga_image_scanner: RTL

Display stage downstream of the uniciclo processor/memory subsystem. Generates 640x480@60 Hz VGA timing from the 50 MHz system clock and scans the processed 8-bit grayscale image memory, reading one address per pixel. It converts each byte to gray RGB and drives the DAC/connector pins. Display is enabled by the processor's memory-mapped `vga` flag, which is sampled once per frame so a frame is never torn.

---
 rtl/vga_image_scanner_if.sv | 37 +++
 rtl/vga_image_scanner.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/vga_image_scanner_if.sv
// rtl/vga_image_scanner_if.sv - image-memory read port and VGA DAC/connector pins
//
// Signals:
//   img_adr   image-memory read address, driven by the scanner
//   img_data  pixel byte returned by the memory one clk after img_adr
//   vga_clk   pixel clock (clk/2)
//   hsync     horizontal sync, active low
//   vsync     vertical sync, active low
//   blank_n   high in the visible area
//   sync_n    composite sync to the DAC, held at 0
//   red/green/blue  gray pixel value on all three channels
// Modports: master = scanner side, slave = memory/DAC side.
`timescale 1ns/1ps
interface vga_image_scanner_if #(
    parameter int ADR_W = 18
);
    logic [ADR_W-1:0] img_adr;
    logic [7:0]       img_data;
    logic             vga_clk;
    logic             hsync;
    logic             vsync;
    logic             blank_n;
    logic             sync_n;
    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;

    modport master (
        output img_adr, vga_clk, hsync, vsync, blank_n, sync_n, red, green, blue,
        input  img_data
    );

    modport slave (
        input  img_adr, vga_clk, hsync, vsync, blank_n, sync_n, red, green, blue,
        output img_data
    );
endinterface

// File: rtl/vga_image_scanner.sv
// rtl/vga_image_scanner.sv - VGA timing generator scanning an 8-bit grayscale image memory
//
// Ports:
//   clk          system clock (50 MHz)
//   reset        asynchronous active-low reset
//   show         display enable, sampled once per frame at h=0, v=0
//   frame_start  one-clk pulse on the pixel edge where h=0, v=0
//   vga          memory read port and VGA pins (vga_image_scanner_if.master)
// Timing parameters default to 640x480@60; IMG_W x IMG_H image sits top-left.
`timescale 1ns/1ps
module vga_image_scanner #(
    parameter int          IMG_W  = 256,
    parameter int          IMG_H  = 256,
    parameter int          ADR_W  = 18,
    parameter logic [7:0]  BG     = 8'h00,
    parameter int          H_VIS  = 640,
    parameter int          H_FP   = 16,
    parameter int          H_SYNC = 96,
    parameter int          H_BP   = 48,
    parameter int          V_VIS  = 480,
    parameter int          V_FP   = 10,
    parameter int          V_SYNC = 2,
    parameter int          V_BP   = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 show,
    output logic                 frame_start,
    vga_image_scanner_if.master  vga
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
    localparam logic [HW-1:0] HS_FIRST = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_LAST  = HW'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] IMG_W_C  = HW'(IMG_W);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
    localparam logic [VW-1:0] VS_FIRST = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_LAST  = VW'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] IMG_H_C  = VW'(IMG_H);

    // Counter stage: position of the pixel whose address is being issued
    logic             ph_q;
    logic [HW-1:0]    h_q, h_d;
    logic [VW-1:0]    v_q, v_d;
    logic             show_q, show_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    // Pipeline stage: position of the pixel whose data is arriving now
    logic [HW-1:0]    h1_q;
    logic [VW-1:0]    v1_q;
    // Pin stage
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    logic [7:0]       gray_q, gray_d;
    logic             fs_q;

    logic             pix_en;
    logic             at_origin;
    logic             in_img;
    logic             in_img1;
    logic [ADR_W-1:0] lin_adr;

    assign pix_en    = ph_q;
    assign at_origin = (h_q == '0) && (v_q == '0);
    assign in_img    = (h_q < IMG_W_C) && (v_q < IMG_H_C);
    assign in_img1   = (h1_q < IMG_W_C) && (v1_q < IMG_H_C);
    assign lin_adr   = ADR_W'(v_q) * ADR_W'(IMG_W) + ADR_W'(h_q);

    // State register. The pipeline position resets to the last pixel of a
    // frame (blanked, outside both sync pulses) so the first pixel edge after
    // reset drives exactly the idle pin values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_q    <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            show_q  <= 1'b0;
            adr_q   <= '0;
            h1_q    <= H_LAST;
            v1_q    <= V_LAST;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            gray_q  <= 8'h00;
            fs_q    <= 1'b0;
        end else begin
            ph_q <= ~ph_q;
            fs_q <= pix_en && at_origin;
            if (pix_en) begin
                h_q     <= h_d;
                v_q     <= v_d;
                show_q  <= show_d;
                adr_q   <= adr_d;
                h1_q    <= h_q;
                v1_q    <= v_q;
                hs_q    <= hs_d;
                vs_q    <= vs_d;
                blank_q <= blank_d;
                gray_q  <= gray_d;
            end
        end
    end

    // Next-state: raster counters, per-frame show latch, read address
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        show_d = show_q;
        adr_d  = in_img ? lin_adr : '0;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
        if (at_origin) begin
            show_d = show;
        end
    end

    // Pin values for the pixel whose memory data is on img_data now
    always_comb begin
        hs_d    = !((h1_q >= HS_FIRST) && (h1_q <= HS_LAST));
        vs_d    = !((v1_q >= VS_FIRST) && (v1_q <= VS_LAST));
        blank_d = (h1_q < H_VIS_C) && (v1_q < V_VIS_C);
        gray_d  = 8'h00;
        if (blank_d) begin
            gray_d = (show_q && in_img1) ? vga.img_data : BG;
        end
    end

    assign vga.img_adr  = adr_q;
    assign vga.vga_clk  = ph_q;
    assign vga.hsync    = hs_q;
    assign vga.vsync    = vs_q;
    assign vga.blank_n  = blank_q;
    assign vga.sync_n   = 1'b0;
    assign vga.red      = gray_q;
    assign vga.green    = gray_q;
    assign vga.blue     = gray_q;
    assign frame_start  = fs_q;
endmodule
